// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: UART transmit path, parallel word in, framed serial bits out
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   p_data     parallel word, sampled when a frame is accepted
//   data_valid request to send p_data (ignored while busy)
//   par_en     1 = append a parity bit
//   par_typ    0 = even parity, 1 = odd parity
//   prescale   clk cycles per serial bit (0 behaves as 1)
//   tx_out     registered serial line, idles high
//   busy       high for the whole frame
// Build option: define UART_TX_STOP2_EN for two stop bits.
module uart_tx_serializer #(
   parameter int DWIDTH = 8,
   parameter int PWIDTH = 6
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DWIDTH-1:0] p_data,
   input  logic              data_valid,
   input  logic              par_en,
   input  logic              par_typ,
   input  logic [PWIDTH-1:0] prescale,
   output logic              tx_out,
   output logic              busy
);
   localparam int IW = $clog2(DWIDTH + 1);
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
   state_t state, state_n;
   logic [PWIDTH-1:0] cnt, cnt_n, pre_r, pre_n, p_last;
   logic [IW-1:0] idx, idx_n;
   logic [DWIDTH-1:0] sh, sh_n, sh_nx;
   logic par_en_r, par_en_n, par_bit_r, par_bit_n, tx_n, busy_n, bit_end;
   // Data is shifted out LSB first; parity is computed once at accept time
   // so the shift register does not need to keep the whole word.
   assign p_last  = (pre_r == '0) ? '0 : pre_r - 1'b1;
   assign bit_end = cnt == p_last;
   assign sh_nx   = sh >> 1;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         cnt       <= '0;
         idx       <= '0;
         sh        <= '0;
         pre_r     <= '0;
         par_en_r  <= 1'b0;
         par_bit_r <= 1'b0;
         tx_out    <= 1'b1;
         busy      <= 1'b0;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         idx       <= idx_n;
         sh        <= sh_n;
         pre_r     <= pre_n;
         par_en_r  <= par_en_n;
         par_bit_r <= par_bit_n;
         tx_out    <= tx_n;
         busy      <= busy_n;
      end
   end
   always_comb begin
      state_n   = state;
      cnt_n     = cnt + 1'b1;
      idx_n     = idx;
      sh_n      = sh;
      pre_n     = pre_r;
      par_en_n  = par_en_r;
      par_bit_n = par_bit_r;
      tx_n      = tx_out;
      busy_n    = busy;
      if (state == IDLE) begin
         cnt_n  = '0;
         idx_n  = '0;
         tx_n   = 1'b1;
         busy_n = 1'b0;
         if (data_valid) begin
            sh_n      = p_data;
            pre_n     = prescale;
            par_en_n  = par_en;
            par_bit_n = ^p_data ^ par_typ;
            state_n   = START;
            tx_n      = 1'b0;
            busy_n    = 1'b1;
         end
      end else if (bit_end) begin
         cnt_n = '0;
         case (state)
            START: begin
               state_n = DATA;
               idx_n   = '0;
               tx_n    = sh[0];
            end
            DATA: begin
               if (idx == IW'(DWIDTH - 1)) begin
                  state_n = par_en_r ? PARITY : STOP;
                  idx_n   = '0;
                  tx_n    = par_en_r ? par_bit_r : 1'b1;
               end else begin
                  idx_n = idx + 1'b1;
                  sh_n  = sh_nx;
                  tx_n  = sh_nx[0];
               end
            end
            PARITY: begin
               state_n = STOP;
               tx_n    = 1'b1;
            end
            STOP: begin
`ifdef UART_TX_STOP2_EN
               // idx counts the stop bits already completed
               if (idx == '0) begin
                  idx_n = IW'(1);
               end else begin
                  state_n = IDLE;
                  idx_n   = '0;
                  busy_n  = 1'b0;
               end
`else
               state_n = IDLE;
               busy_n  = 1'b0;
`endif
            end
            default: state_n = IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb_uart_tx_serializer: directed self-checking bench for uart_tx_serializer
module tb_uart_tx_serializer;
`ifdef UART_TX_STOP2_EN
   localparam int S2 = 1;
`else
   localparam int S2 = 0;
`endif
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [7:0] p_data = '0;
   logic data_valid = 1'b0;
   logic par_en = 1'b0;
   logic par_typ = 1'b0;
   logic [5:0] prescale = '0;
   logic tx_out, busy;
   int checks = 0;
   int errors = 0;
   uart_tx_serializer #(.DWIDTH(8), .PWIDTH(6)) dut (
      .clk(clk), .rst(rst), .p_data(p_data), .data_valid(data_valid),
      .par_en(par_en), .par_typ(par_typ), .prescale(prescale),
      .tx_out(tx_out), .busy(busy)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   // Called at the negedge just after the accepting edge. Checks every cycle
   // of the frame, the busy length, and the idle cycle that follows.
   task automatic verify(input string tag, input logic [7:0] d, input int p,
                         input logic pen, input logic exp_par, input int exp_len);
      logic lv[0:12];
      int n, blen;
      lv[0] = 1'b0;
      for (int k = 0; k < 8; k++) lv[1+k] = d[k];
      n = 9;
      if (pen) begin
         lv[n] = exp_par;
         n++;
      end
      lv[n] = 1'b1;
      n++;
      if (S2 == 1) begin
         lv[n] = 1'b1;
         n++;
      end
      blen = 0;
      for (int i = 0; i < n; i++) begin
         for (int c = 0; c < p; c++) begin
            chk($sformatf("%s_bit%0d_cyc%0d", tag, i, c), {31'd0, tx_out}, {31'd0, lv[i]});
            if (busy === 1'b1) blen++;
            @(negedge clk);
         end
      end
      chk({tag, "_busy_len"}, blen, exp_len);
      chk({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
      chk({tag, "_idle_tx"}, {31'd0, tx_out}, 32'd1);
   endtask
   task automatic launch(input logic [7:0] d, input logic [5:0] pre, input logic pen, input logic pt);
      @(negedge clk);
      p_data = d;
      prescale = pre;
      par_en = pen;
      par_typ = pt;
      data_valid = 1'b1;
      @(negedge clk);
      data_valid = 1'b0;
   endtask
   initial begin
      #2 rst = 1'b0;
      #3;
      chk("reset_tx", {31'd0, tx_out}, 32'd1);
      chk("reset_busy", {31'd0, busy}, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("idle_tx", {31'd0, tx_out}, 32'd1);
      // 1: 0xA5, even parity -> parity 0, 11 bits * 4
      launch(8'hA5, 6'd4, 1'b1, 1'b0);
      verify("t1", 8'hA5, 4, 1'b1, 1'b0, 44 + S2 * 4);
      // 2: odd parity
      launch(8'h01, 6'd4, 1'b1, 1'b1);
      verify("t2a", 8'h01, 4, 1'b1, 1'b0, 44 + S2 * 4);
      launch(8'h00, 6'd4, 1'b1, 1'b1);
      verify("t2b", 8'h00, 4, 1'b1, 1'b1, 44 + S2 * 4);
      // 3: prescale 1, no parity
      launch(8'hFF, 6'd1, 1'b0, 1'b0);
      verify("t3", 8'hFF, 1, 1'b0, 1'b0, 10 + S2);
      // 4: back-to-back with data_valid held, p_data changed mid-frame
      @(negedge clk);
      p_data = 8'h3C;
      prescale = 6'd8;
      par_en = 1'b0;
      data_valid = 1'b1;
      @(negedge clk);
      p_data = 8'hC3;
      prescale = 6'd2;
      par_en = 1'b1;
      verify("t4a", 8'h3C, 8, 1'b0, 1'b0, 80 + S2 * 8);
      prescale = 6'd8;
      par_en = 1'b0;
      @(negedge clk);
      data_valid = 1'b0;
      p_data = 8'hFF;
      verify("t4b", 8'hC3, 8, 1'b0, 1'b0, 80 + S2 * 8);
      // 5: async reset during data bit 3, then a clean frame
      launch(8'hA5, 6'd4, 1'b1, 1'b0);
      repeat (18) @(negedge clk);
      chk("t5_pre_busy", {31'd0, busy}, 32'd1);
      chk("t5_pre_tx_bit3", {31'd0, tx_out}, 32'd0);
      #1 rst = 1'b0;
      #1;
      chk("t5_rst_tx", {31'd0, tx_out}, 32'd1);
      chk("t5_rst_busy", {31'd0, busy}, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("t5_post_busy", {31'd0, busy}, 32'd0);
      launch(8'h55, 6'd4, 1'b0, 1'b0);
      verify("t5", 8'h55, 4, 1'b0, 1'b0, 40 + S2 * 4);
      // 6: zero word, no parity; two stop bits when enabled
      launch(8'h00, 6'd4, 1'b0, 1'b0);
      verify("t6", 8'h00, 4, 1'b0, 1'b0, 40 + S2 * 4);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
